r88_intctl: RTL and testbench

- Interrupt controller directly upstream of the Rocket88 core: merges 8 peripheral interrupt sources and one NMI source into the core's irq and nmiReq inputs.
- Memory-mapped on the core's external bus (extA, readMem, writeMem, data).
- Provides pending, mask, edge-config and vector registers so the ISR can identify and acknowledge the highest-priority source.

---
 rtl/r88_pkg.sv | 36 +++
 rtl/r88_edge_det.sv | 46 ++++
 rtl/r88_intctl.sv | 160 ++++++++++++++++
 tb/tb_r88_intctl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/r88_pkg.sv
// r88_pkg: shared definitions for the Rocket88 interrupt controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: register offsets within the 4-byte window, the "no source" vector
// value, the priority-encoder result type and the encoder function itself.
package r88_pkg;

   // Register offsets (extA[1:0]) inside the controller window.
   localparam logic [1:0] R88_IC_PEND   = 2'd0;
   localparam logic [1:0] R88_IC_MASK   = 2'd1;
   localparam logic [1:0] R88_IC_EDGE   = 2'd2;
   localparam logic [1:0] R88_IC_VECTOR = 2'd3;

   // VECTOR read value when nothing is both pending and enabled.
   localparam logic [7:0] R88_IC_VEC_NONE = 8'h80;

   typedef struct packed {
      logic       vld;
      logic [2:0] idx;
   } r88Prio_t;

   // Lowest set bit wins: bit 0 is the highest-priority source.
   function automatic r88Prio_t r88PrioEnc(input logic [7:0] vec);
      r88Prio_t res;
      res.vld = 1'b0;
      res.idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) begin
            res.vld = 1'b1;
            res.idx = 3'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/r88_edge_det.sv
// r88_edge_det: 1-bit source conditioner with rising-edge detection.
// Latency: level/rise are combinational from srcIn (or 2 cycles behind it when
//          R88_INTCTL_SYNC_EN is defined, which adds a 2-flop synchronizer).
// Backpressure: none; the source is sampled every cycle.
// Ports: clk/rst (async active-high), srcIn raw source, level conditioned
//        source, rise = level & ~previous level.
module r88_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic srcIn,
   output logic level,
   output logic rise
);

`ifdef R88_INTCTL_SYNC_EN
   logic syncQ1;
   logic syncQ2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncQ1 <= 1'b0;
         syncQ2 <= 1'b0;
      end else begin
         syncQ1 <= srcIn;
         syncQ2 <= syncQ1;
      end
   end

   assign level = syncQ2;
`else
   // Source is already synchronous to clk.
   assign level = srcIn;
`endif

   logic prevQ;

   // History tracks the source unconditionally, so a later switch into edge
   // mode while the source is high does not see a phantom edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prevQ <= 1'b0;
      else     prevQ <= level;
   end

   assign rise = level & ~prevQ;

endmodule

// File: rtl/r88_intctl.sv
// r88_intctl: 8-source maskable interrupt + NMI controller for the Rocket88 core.
// Latency: reads combinational; irq registered one cycle after PEND&MASK changes;
//          nmiReq rises the cycle after an nmiSrc edge for NMI_PULSE cycles.
// Backpressure: none; bus accesses complete in the cycle they are presented.
// Ports: sysClock, resetReq (async active-high), extA/readMem/writeMem/dataIn bus
//        side, dataOut/dataOutEn read return, irqSrc[7:0] (bit 0 highest),
//        nmiSrc (rising edge), irq and nmiReq to the core.
// Build option: define R88_INTCTL_SYNC_EN to add 2-flop synchronizers on all sources.
// Parameters: BASE_ADDR must be 4-byte aligned; NMI_PULSE must be 1..15.
module r88_intctl
   import r88_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter int          NMI_PULSE = 2
) (
   input  logic        sysClock,
   input  logic        resetReq,
   input  logic [15:0] extA,
   input  logic        readMem,
   input  logic        writeMem,
   input  logic [7:0]  dataIn,
   output logic [7:0]  dataOut,
   output logic        dataOutEn,
   input  logic [7:0]  irqSrc,
   input  logic        nmiSrc,
   output logic        irq,
   output logic        nmiReq
);

   logic [7:0] srcLvl;
   logic [7:0] srcRise;
   logic       nmiLvl;
   logic       nmiRise;

   logic [7:0] maskReg;
   logic [7:0] edgeReg;
   logic [7:0] edgePend;
   logic       rdPrev;
   logic [3:0] nmiCnt;

   // ------------------------------------------------------------------
   // Source conditioning
   // ------------------------------------------------------------------
   for (genvar g = 0; g < 8; g++) begin : gIrqDet
      r88_edge_det uDet (
         .clk   (sysClock),
         .rst   (resetReq),
         .srcIn (irqSrc[g]),
         .level (srcLvl[g]),
         .rise  (srcRise[g])
      );
   end

   r88_edge_det uNmiDet (
      .clk   (sysClock),
      .rst   (resetReq),
      .srcIn (nmiSrc),
      .level (nmiLvl),
      .rise  (nmiRise)
   );

   // nmiLvl is only consumed through the edge detector's rise output.
   logic nmiLvlUnused;
   assign nmiLvlUnused = nmiLvl;

   // ------------------------------------------------------------------
   // Decode and pending / priority
   // ------------------------------------------------------------------
   logic       hit;
   logic [1:0] regOff;
   logic       wrHit;
   logic       ackStb;

   assign hit    = (extA[15:2] == BASE_ADDR[15:2]);
   assign regOff = extA[1:0];
   assign wrHit  = writeMem & hit;
   // A combined read+write strobe performs only the write, so no ack.
   assign ackStb = readMem & ~writeMem & ~rdPrev & hit & (regOff == R88_IC_VECTOR);

   logic [7:0] pend;
   logic [7:0] active;
   r88Prio_t   prio;
   logic [7:0] vector;

   // Level-mode bits reflect the live source; edge-mode bits the latched pend.
   assign pend   = (edgeReg & edgePend) | (~edgeReg & srcLvl);
   assign active = pend & maskReg;
   assign prio   = r88PrioEnc(active);
   assign vector = prio.vld ? {5'b00000, prio.idx} : R88_IC_VEC_NONE;

   logic [7:0] ackClr;
   logic [7:0] w1cClr;
   logic [7:0] edgeSet;
   logic [7:0] edgePendNxt;

   always_comb begin
      ackClr = 8'h00;
      // Level sources are never cleared by an acknowledge.
      if (ackStb && prio.vld && edgeReg[prio.idx]) ackClr[prio.idx] = 1'b1;
   end

   assign w1cClr      = (wrHit && regOff == R88_IC_PEND) ? dataIn : 8'h00;
   assign edgeSet     = edgeReg & srcRise;
   // Set has priority over any clear arriving on the same edge.
   assign edgePendNxt = edgeSet | (edgePend & ~(w1cClr | ackClr));

   // ------------------------------------------------------------------
   // Read return
   // ------------------------------------------------------------------
   always_comb begin
      dataOut   = 8'h00;
      dataOutEn = 1'b0;
      if (readMem && hit) begin
         dataOutEn = 1'b1;
         case (regOff)
            R88_IC_PEND:   dataOut = pend;
            R88_IC_MASK:   dataOut = maskReg;
            R88_IC_EDGE:   dataOut = edgeReg;
            R88_IC_VECTOR: dataOut = vector;
            default:       dataOut = 8'h00;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Register file, irq, read-strobe history
   // ------------------------------------------------------------------
   always_ff @(posedge sysClock or posedge resetReq) begin
      if (resetReq) begin
         maskReg  <= 8'h00;
         edgeReg  <= 8'h00;
         edgePend <= 8'h00;
         rdPrev   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (wrHit && regOff == R88_IC_MASK) maskReg <= dataIn;
         if (wrHit && regOff == R88_IC_EDGE) edgeReg <= dataIn;
         edgePend <= edgePendNxt;
         rdPrev   <= readMem;
         irq      <= |active;
      end
   end

   // ------------------------------------------------------------------
   // NMI pulse stretcher (retriggerable, not maskable)
   // ------------------------------------------------------------------
   always_ff @(posedge sysClock or posedge resetReq) begin
      if (resetReq) begin
         nmiCnt <= 4'd0;
      end else if (nmiRise) begin
         nmiCnt <= 4'(NMI_PULSE);
      end else if (nmiCnt != 4'd0) begin
         nmiCnt <= nmiCnt - 4'd1;
      end
   end

   // Driven straight from the counter flops so reset drops it at once.
   assign nmiReq = (nmiCnt != 4'd0);

endmodule

// File: tb/tb_r88_intctl.sv
module tb_r88_intctl;

   logic        sysClock = 1'b0;
   logic        resetReq;
   logic [15:0] extA;
   logic        readMem;
   logic        writeMem;
   logic [7:0]  dataIn;
   logic [7:0]  dataOut;
   logic        dataOutEn;
   logic [7:0]  irqSrc;
   logic        nmiSrc;
   logic        irq;
   logic        nmiReq;

   int total = 0;
   int bad   = 0;
   logic [7:0] expQ[$];

   always #5 sysClock = ~sysClock;

   r88_intctl #(.BASE_ADDR(16'hFF00), .NMI_PULSE(2)) dut (
      .sysClock  (sysClock),
      .resetReq  (resetReq),
      .extA      (extA),
      .readMem   (readMem),
      .writeMem  (writeMem),
      .dataIn    (dataIn),
      .dataOut   (dataOut),
      .dataOutEn (dataOutEn),
      .irqSrc    (irqSrc),
      .nmiSrc    (nmiSrc),
      .irq       (irq),
      .nmiReq    (nmiReq)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read data is queued as the access is driven, popped on sample.
   task automatic rd(input logic [15:0] a, input logic [7:0] e, input string tag);
      expQ.push_back(e);
      @(negedge sysClock);
      extA = a;
      readMem = 1'b1;
      #1;
      chk({tag, ".en"}, {7'b0, dataOutEn}, 8'h01);
      chk(tag, dataOut, expQ.pop_front());
      @(negedge sysClock);
      readMem = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge sysClock);
      extA = a;
      dataIn = d;
      writeMem = 1'b1;
      @(negedge sysClock);
      writeMem = 1'b0;
   endtask

   task automatic pulseSrc(input logic [7:0] v);
      @(negedge sysClock);
      irqSrc = v;
      @(negedge sysClock);
      irqSrc = 8'h00;
   endtask

   initial begin
      int hi;
      resetReq = 1'b1;
      extA = 16'h0000;
      readMem = 1'b0;
      writeMem = 1'b0;
      dataIn = 8'h00;
      irqSrc = 8'h00;
      nmiSrc = 1'b0;
      repeat (2) @(negedge sysClock);
      resetReq = 1'b0;
      @(negedge sysClock);

      // Reset state
      chk("rst.irq", {7'b0, irq}, 8'h00);
      chk("rst.nmi", {7'b0, nmiReq}, 8'h00);
      rd(16'hFF00, 8'h00, "rst.pend");
      rd(16'hFF01, 8'h00, "rst.mask");
      rd(16'hFF02, 8'h00, "rst.edge");
      rd(16'hFF03, 8'h80, "rst.vec");

      // Outside the window nothing is driven
      @(negedge sysClock);
      extA = 16'hFF04;
      readMem = 1'b1;
      #1;
      chk("miss.en", {7'b0, dataOutEn}, 8'h00);
      chk("miss.dat", dataOut, 8'h00);
      extA = 16'hFEFF;
      #1;
      chk("miss2.en", {7'b0, dataOutEn}, 8'h00);
      readMem = 1'b0;

      // Edge IRQ with acknowledge through VECTOR
      wr(16'hFF02, 8'hFF);
      wr(16'hFF01, 8'h0C);
      pulseSrc(8'h08);
      @(negedge sysClock);
      chk("edge.irq1", {7'b0, irq}, 8'h01);
      pulseSrc(8'h04);
      rd(16'hFF00, 8'h0C, "edge.pend");
      rd(16'hFF03, 8'h02, "edge.vec1");
      rd(16'hFF03, 8'h03, "edge.vec2");
      chk("edge.irqHold", {7'b0, irq}, 8'h01);
      @(negedge sysClock);
      chk("edge.irqFall", {7'b0, irq}, 8'h00);
      rd(16'hFF03, 8'h80, "edge.vec3");

      // A held read strobe acknowledges only once
      pulseSrc(8'h0C);
      @(negedge sysClock);
      extA = 16'hFF03;
      readMem = 1'b1;
      #1;
      expQ.push_back(8'h02);
      chk("hold.v0", dataOut, expQ.pop_front());
      @(negedge sysClock);
      #1;
      expQ.push_back(8'h03);
      chk("hold.v1", dataOut, expQ.pop_front());
      @(negedge sysClock);
      #1;
      expQ.push_back(8'h03);
      chk("hold.v2", dataOut, expQ.pop_front());
      readMem = 1'b0;
      rd(16'hFF03, 8'h03, "hold.after");
      rd(16'hFF03, 8'h80, "hold.empty");

      // Level IRQ: not cleared by ack or W1C
      wr(16'hFF02, 8'h00);
      wr(16'hFF01, 8'h01);
      @(negedge sysClock);
      irqSrc = 8'h01;
      rd(16'hFF03, 8'h00, "lvl.vec1");
      rd(16'hFF03, 8'h00, "lvl.vec2");
      wr(16'hFF00, 8'h01);
      rd(16'hFF00, 8'h01, "lvl.w1c");
      @(negedge sysClock);
      chk("lvl.irq", {7'b0, irq}, 8'h01);
      irqSrc = 8'h00;
      @(negedge sysClock);
      chk("lvl.irqDrop", {7'b0, irq}, 8'h00);

      // Level->edge switch with source high: no phantom edge
      @(negedge sysClock);
      irqSrc = 8'h02;
      wr(16'hFF02, 8'h02);
      rd(16'hFF00, 8'h00, "switch.pend");
      irqSrc = 8'h00;

      // Masking
      wr(16'hFF01, 8'h00);
      wr(16'hFF02, 8'hFF);
      pulseSrc(8'h20);
      rd(16'hFF00, 8'h20, "mask.pend");
      chk("mask.irq0", {7'b0, irq}, 8'h00);
      wr(16'hFF01, 8'h20);
      @(negedge sysClock);
      chk("mask.irq1", {7'b0, irq}, 8'h01);
      wr(16'hFF00, 8'h20);
      rd(16'hFF00, 8'h00, "mask.clr");

      // Set beats W1C on the same edge
      @(negedge sysClock);
      extA = 16'hFF00;
      dataIn = 8'h01;
      writeMem = 1'b1;
      irqSrc = 8'h01;
      @(negedge sysClock);
      writeMem = 1'b0;
      irqSrc = 8'h00;
      rd(16'hFF00, 8'h01, "race.pend");
      wr(16'hFF00, 8'h01);
      rd(16'hFF00, 8'h00, "race.clr");

      // Read+write together: write to VECTOR ignored, no ack side effect
      pulseSrc(8'h20);
      @(negedge sysClock);
      extA = 16'hFF03;
      dataIn = 8'h00;
      writeMem = 1'b1;
      readMem = 1'b1;
      @(negedge sysClock);
      writeMem = 1'b0;
      readMem = 1'b0;
      rd(16'hFF03, 8'h05, "rw.vec");
      rd(16'hFF03, 8'h80, "rw.acked");

      // NMI single pulse
      @(negedge sysClock);
      nmiSrc = 1'b1;
      hi = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge sysClock);
         if (nmiReq) hi++;
      end
      chk("nmi.width", 8'(hi), 8'd2);
      nmiSrc = 1'b0;
      @(negedge sysClock);

      // NMI retrigger during the pulse
      @(negedge sysClock);
      nmiSrc = 1'b1;
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge sysClock);
         if (nmiReq) hi++;
         if (i == 0) nmiSrc = 1'b0;
         if (i == 1) nmiSrc = 1'b1;
      end
      chk("nmi.retrig", 8'(hi), 8'd4);
      chk("nmi.unmasked.irq", {7'b0, irq}, 8'h00);
      nmiSrc = 1'b0;
      @(negedge sysClock);

      // Reset in the middle of an NMI pulse
      @(negedge sysClock);
      nmiSrc = 1'b1;
      @(negedge sysClock);
      chk("rstmid.pre", {7'b0, nmiReq}, 8'h01);
      #2;
      resetReq = 1'b1;
      #1;
      chk("rstmid.nmi", {7'b0, nmiReq}, 8'h00);
      @(negedge sysClock);
      nmiSrc = 1'b0;
      @(negedge sysClock);
      resetReq = 1'b0;
      @(negedge sysClock);
      chk("rstmid.after", {7'b0, nmiReq}, 8'h00);
      rd(16'hFF01, 8'h00, "rstmid.mask");
      rd(16'hFF02, 8'h00, "rstmid.edge");
      rd(16'hFF03, 8'h80, "rstmid.vec");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
